// File: rtl/sap_timing_decoder.sv
// sap_timing_decoder
//   Timing-and-decode front end of a SAP-style control sequencer.
//   - A one-hot ring counter steps through the T-states of each machine cycle:
//     T1 (t[T_STATES-1]) down to the last state (t[0]), then wraps to T1.
//   - A combinational opcode decoder drives one-hot instruction strobes,
//     an active-low halt and an illegal-opcode flag.
//
// Optional build macro: HALT_FREEZE_EN
//   If this macro is defined, the ring stops at T4 once a halt is decoded there.
//   It stays stopped until clr is asserted, even if op_code changes.
//   If the macro is undefined, the ring runs freely and halting is handled downstream.
//
// Ports
//   clk       in   system clock, rising edge
//   clr       in   synchronous active-low reset (ring -> T1)
//   op_code   in   [3:0] opcode from the instruction register
//   t         out  [T_STATES-1:0] one-hot timing state
//   lda, add, sub, out, xor_op, and_op, or_op, cmp_op
//             out  instruction strobes
//   alu_op    out  OR of the ALU strobes (add/sub/xor/and/or/cmp)
//   low_halt  out  0 only for the HLT opcode
//   illegal   out  1 for unassigned opcodes
module sap_timing_decoder #(
  parameter int T_STATES = 6
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [3:0]          op_code,
  output logic [T_STATES-1:0] t,
  output logic                lda,
  output logic                add,
  output logic                sub,
  output logic                out,
  output logic                xor_op,
  output logic                and_op,
  output logic                or_op,
  output logic                cmp_op,
  output logic                alu_op,
  output logic                low_halt,
  output logic                illegal
);

  localparam logic [T_STATES-1:0] T1 = {1'b1, {(T_STATES-1){1'b0}}};
  localparam int T4_IDX = T_STATES - 4;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  logic t_onehot;
  assign t_onehot = (t != '0) && ((t & (t - 1'b1)) == '0);

`ifdef HALT_FREEZE_EN
  logic frozen;

  always_ff @(posedge clk) begin
    if (!clr) begin
      t      <= T1;
      frozen <= 1'b0;
    end else if (!t_onehot) begin
      // Recover from an upset by restarting the cycle.
      t      <= T1;
      frozen <= 1'b0;
    end else if (frozen || (t[T4_IDX] && !low_halt)) begin
      // The frozen flag keeps the hold after op_code moves away from HLT.
      frozen <= 1'b1;
    end else begin
      t      <= {t[0], t[T_STATES-1:1]};
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!clr || !t_onehot)
      t <= T1;
    else
      t <= {t[0], t[T_STATES-1:1]};
  end
`endif

  // Decoder: no state, zero latency, independent of clr.
  always_comb begin
    lda      = 1'b0;
    add      = 1'b0;
    sub      = 1'b0;
    out      = 1'b0;
    xor_op   = 1'b0;
    and_op   = 1'b0;
    or_op    = 1'b0;
    cmp_op   = 1'b0;
    low_halt = 1'b1;
    illegal  = 1'b0;
    case (op_code)
      4'b0000: lda      = 1'b1;
      4'b0001: add      = 1'b1;
      4'b0010: sub      = 1'b1;
      4'b0011: xor_op   = 1'b1;
      4'b0100: and_op   = 1'b1;
      4'b0101: or_op    = 1'b1;
      4'b0110: cmp_op   = 1'b1;
      4'b1110: out      = 1'b1;
      4'b1111: low_halt = 1'b0;
      default: illegal  = 1'b1;
    endcase
  end

  assign alu_op = add | sub | xor_op | and_op | or_op | cmp_op;

endmodule

// File: tb/tb_sap_timing_decoder.sv
// Directed bench for sap_timing_decoder. The stimulus queues the expected response
// for every clock. A monitor compares that response one time unit after each rising edge.
module tb_sap_timing_decoder;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] op_code = 4'd0;
  logic [5:0] t;
  logic lda, add, sub, out, xor_op, and_op, or_op, cmp_op, alu_op, low_halt, illegal;

  sap_timing_decoder #(.T_STATES(6)) dut (
    .clk(clk), .clr(clr), .op_code(op_code), .t(t),
    .lda(lda), .add(add), .sub(sub), .out(out), .xor_op(xor_op),
    .and_op(and_op), .or_op(or_op), .cmp_op(cmp_op), .alu_op(alu_op),
    .low_halt(low_halt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Decoder vector: {lda,add,sub,out,xor,and,or,cmp,alu_op,low_halt,illegal}
  logic [10:0] dec;
  assign dec = {lda, add, sub, out, xor_op, and_op, or_op, cmp_op, alu_op, low_halt, illegal};

  logic [10:0] dec_tab [16];
  logic [5:0]  ring [6];

  typedef struct {
    string       name;
    logic [5:0]  t;
    logic [10:0] dec;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (t !== e.t) begin
          errors++;
          $display("FAIL %s t: got %b expected %b", e.name, t, e.t);
        end
        checks++;
        if (dec !== e.dec) begin
          errors++;
          $display("FAIL %s strobes: got %b expected %b", e.name, dec, e.dec);
        end
      end
    end
  end

  task automatic step(input logic c, input logic [3:0] op, input logic [5:0] et, input string nm);
    @(negedge clk);
    clr = c;
    op_code = op;
    q.push_back('{nm, et, dec_tab[op]});
  endtask

  initial begin
    dec_tab[0]  = 11'b10000000010;
    dec_tab[1]  = 11'b01000000110;
    dec_tab[2]  = 11'b00100000110;
    dec_tab[3]  = 11'b00001000110;
    dec_tab[4]  = 11'b00000100110;
    dec_tab[5]  = 11'b00000010110;
    dec_tab[6]  = 11'b00000001110;
    for (int i = 7; i <= 13; i++) dec_tab[i] = 11'b00000000011;
    dec_tab[14] = 11'b00010000010;
    dec_tab[15] = 11'b00000000000;
    // The sequence after T1: T2, T3, T4, T5, T6, then T1 again.
    ring[0] = 6'b010000; ring[1] = 6'b001000; ring[2] = 6'b000100;
    ring[3] = 6'b000010; ring[4] = 6'b000001; ring[5] = 6'b100000;

    // Reset and full rotation
    step(1'b0, 4'd0, 6'b100000, "reset");
    for (int i = 0; i < 6; i++) step(1'b1, 4'd0, ring[i], "rotate");

    // Mid-cycle reset
    for (int i = 0; i < 3; i++) step(1'b1, 4'd0, ring[i], "pre_mid");
    step(1'b0, 4'd0, 6'b100000, "mid_reset");
    for (int i = 0; i < 2; i++) step(1'b1, 4'd0, ring[i], "post_mid");

    // Decoder sweep with clr held low, so t remains at T1.
    // This also shows that the decoder does not depend on clr.
    for (int i = 0; i < 16; i++) step(1'b0, 4'(i), 6'b100000, $sformatf("op_%0d", i));

    // Corrupt state: force a value that is not one-hot. The next edge must load T1.
    @(negedge clk);
    clr = 1'b1;
    op_code = 4'd0;
    force dut.t = 6'b101000;
    #1;
    release dut.t;
    q.push_back('{"corrupt", 6'b100000, dec_tab[0]});
    step(1'b1, 4'd0, 6'b010000, "after_corrupt");

    // Halt behaviour
    step(1'b0, 4'd15, 6'b100000, "halt_reset");
`ifdef HALT_FREEZE_EN
    for (int i = 0; i < 3; i++) step(1'b1, 4'd15, ring[i], "halt_run");
    for (int i = 0; i < 10; i++) step(1'b1, 4'd15, 6'b000100, "halt_hold");
    for (int i = 0; i < 3; i++) step(1'b1, 4'd1, 6'b000100, "hold_opchg");
`else
    for (int i = 0; i < 12; i++) step(1'b1, 4'd15, ring[i % 6], "halt_free");
`endif
    step(1'b0, 4'd15, 6'b100000, "halt_clr");
    step(1'b1, 4'd0, 6'b010000, "resume");

    // Wait for the monitor to empty the queue. Stop after a fixed number of cycles.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
